// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU issue unit.
//   PPU_OP_WIDTH / ppu_op_e : PPU custom-instruction operation codes
//   PPU_NUM / MULTI_PPU     : default lane count and whether it exceeds one
//   ppu_tag_t               : tag-queue entry {lane index, destination register, err}
// The lane field of ppu_tag_t is sized from the PPU_NUM default below.
// A top-level PPU_NUM larger than 2**PPU_LANE_W requires raising this default.
package ppu_pkg;

    localparam int PPU_NUM      = 2;
    localparam bit MULTI_PPU    = (PPU_NUM > 1);
    localparam int PPU_OP_WIDTH = 3;
    localparam int PPU_LANE_W   = (PPU_NUM > 1) ? $clog2(PPU_NUM) : 1;

    typedef enum logic [PPU_OP_WIDTH-1:0] {
        PPU_ADD            = 3'd0,
        PPU_SUB            = 3'd1,
        PPU_MUL            = 3'd2,
        PPU_DIV            = 3'd3,
        PPU_FLOAT_TO_POSIT = 3'd4,
        PPU_POSIT_TO_FLOAT = 3'd5
    } ppu_op_e;

    typedef struct packed {
        logic [PPU_LANE_W-1:0] lane;
        logic [4:0]            waddr;
        logic                  err;
    } ppu_tag_t;

endpackage

// File: rtl/ppu_tag_fifo.sv
// ppu_tag_fifo: synchronous FIFO of ppu_tag_t recording the owner of every
// outstanding PPU instruction in program order.
//   clk, rst     : clock, synchronous active-high reset
//   push_i       : write push_tag_i at the tail (ignored while full, even if
//                  a pop happens in the same cycle)
//   pop_i        : drop the head entry (ignored while empty)
//   head_tag_o   : current head entry
//   full_o, empty_o, count_o : occupancy
module ppu_tag_fifo
    import ppu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_i,
    input  ppu_tag_t               push_tag_i,
    input  logic                   pop_i,
    output ppu_tag_t               head_tag_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);

    ppu_tag_t        mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_push) tail_d = tail_q + 1'b1;
        if (do_pop)  head_d = head_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (do_push) mem_q[tail_q] <= push_tag_i;
        end
    end

    assign head_tag_o = mem_q[head_q];
    assign count_o    = count_q;

endmodule

// File: rtl/ppu_issue_unit.sv
// ppu_issue_unit: dispatches decoded PPU operations round-robin across
// PPU_NUM posit lanes and retires their results to register writeback in
// program order.
//   clk, rst                      : clock, synchronous active-high reset
//   req_*                         : operation from ID (valid/ready handshake)
//   lane_valid_o / lane_ready_i   : one-hot issue strobe, per-lane readiness
//   lane_op_o, lane_a_o, lane_b_o : operation broadcast to all lanes
//   lane_res_*                    : per-lane result handshake, lane k in
//                                   lane_res_i[k*DATA_WIDTH +: DATA_WIDTH]
//   wb_*                          : in-order writeback port
//   busy_o                        : instructions outstanding
// Build option PPU_OP_CHECK_EN: op codes 6 and 7 are not issued to a lane;
// they take a tag entry marked err and retire with wb_err_o=1, data 0.
module ppu_issue_unit
    import ppu_pkg::*;
#(
    parameter int PPU_NUM    = ppu_pkg::PPU_NUM,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [PPU_OP_WIDTH-1:0]       req_op_i,
    input  logic [DATA_WIDTH-1:0]         req_a_i,
    input  logic [DATA_WIDTH-1:0]         req_b_i,
    input  logic [4:0]                    req_waddr_i,
    output logic [PPU_NUM-1:0]            lane_valid_o,
    input  logic [PPU_NUM-1:0]            lane_ready_i,
    output logic [PPU_OP_WIDTH-1:0]       lane_op_o,
    output logic [DATA_WIDTH-1:0]         lane_a_o,
    output logic [DATA_WIDTH-1:0]         lane_b_o,
    input  logic [PPU_NUM-1:0]            lane_res_valid_i,
    input  logic [PPU_NUM*DATA_WIDTH-1:0] lane_res_i,
    output logic [PPU_NUM-1:0]            lane_res_ready_o,
    output logic                          wb_valid_o,
    input  logic                          wb_ready_i,
    output logic [4:0]                    wb_waddr_o,
    output logic [DATA_WIDTH-1:0]         wb_data_o,
    output logic                          wb_err_o,
    output logic                          busy_o
);

    localparam logic [PPU_LANE_W-1:0] RR_LAST = PPU_LANE_W'(PPU_NUM - 1);

    logic [PPU_LANE_W-1:0]      rr_q, rr_d;
    logic [PPU_NUM-1:0]         hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0]      hold_data_q [PPU_NUM];
    logic [PPU_NUM-1:0]         capture;

    logic                       op_illegal;
    logic                       accept, issue, pop;
    ppu_tag_t                   push_tag, head_tag;
    logic [PPU_LANE_W-1:0]      head_lane;
    logic                       head_err;
    logic                       fifo_full, fifo_empty;
    logic [$clog2(TAG_DEPTH):0] fifo_count;

`ifdef PPU_OP_CHECK_EN
    assign op_illegal = (req_op_i > PPU_OP_WIDTH'(PPU_POSIT_TO_FLOAT));
`else
    assign op_illegal = 1'b0;
`endif

    // Illegal ops never touch a lane, so only the target lane's readiness
    // gates legal ops. No skip-ahead to another idle lane.
    assign req_ready_o = !rst && !fifo_full && (op_illegal || lane_ready_i[rr_q]);
    assign accept      = req_valid_i && req_ready_o;
    assign issue       = accept && !op_illegal;

    always_comb begin
        lane_valid_o = '0;
        for (int k = 0; k < PPU_NUM; k++) begin
            lane_valid_o[k] = issue && (rr_q == PPU_LANE_W'(k));
        end
    end

    assign lane_op_o = issue ? req_op_i : '0;
    assign lane_a_o  = issue ? req_a_i  : '0;
    assign lane_b_o  = issue ? req_b_i  : '0;

    assign push_tag = '{lane: rr_q, waddr: req_waddr_i, err: op_illegal};

    ppu_tag_fifo #(
        .DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (accept),
        .push_tag_i (push_tag),
        .pop_i      (pop),
        .head_tag_o (head_tag),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // A lane may only overwrite its holding register once the previous
    // result has been retired; lanes stall on lane_res_ready_o meanwhile.
    assign lane_res_ready_o = ~hold_valid_q;
    assign capture          = lane_res_valid_i & lane_res_ready_o;

    assign head_lane  = head_tag.lane;
    assign head_err   = head_tag.err;
    assign wb_valid_o = !fifo_empty && (hold_valid_q[head_lane] || head_err);
    assign wb_waddr_o = wb_valid_o ? head_tag.waddr : '0;
    assign wb_data_o  = (wb_valid_o && !head_err) ? hold_data_q[head_lane] : '0;
    assign pop        = wb_valid_o && wb_ready_i;
    assign busy_o     = (fifo_count != '0);

`ifdef PPU_OP_CHECK_EN
    assign wb_err_o = wb_valid_o && head_err;
`else
    assign wb_err_o = 1'b0;
`endif

    always_comb begin
        rr_d         = rr_q;
        hold_valid_d = hold_valid_q;
        if (issue) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + 1'b1;
        end
        hold_valid_d = hold_valid_d | capture;
        // An err entry owns no lane result, so its pop leaves the holds alone.
        if (pop && !head_err) begin
            hold_valid_d[head_lane] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q         <= '0;
            hold_valid_q <= '0;
            for (int k = 0; k < PPU_NUM; k++) hold_data_q[k] <= '0;
        end else begin
            rr_q         <= rr_d;
            hold_valid_q <= hold_valid_d;
            for (int k = 0; k < PPU_NUM; k++) begin
                if (capture[k]) hold_data_q[k] <= lane_res_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_ppu_issue_unit.sv
`timescale 1ns/1ps
module tb_ppu_issue_unit;
    import ppu_pkg::*;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid_i, req_ready_o;
    logic [2:0]    req_op_i;
    logic [DW-1:0] req_a_i, req_b_i;
    logic [4:0]    req_waddr_i;
    logic [N-1:0]  lane_valid_o, lane_ready_i;
    logic [2:0]    lane_op_o;
    logic [DW-1:0] lane_a_o, lane_b_o;
    logic [N-1:0]  lane_res_valid_i, lane_res_ready_o;
    logic [N*DW-1:0] lane_res_i;
    logic          wb_valid_o, wb_ready_i, wb_err_o, busy_o;
    logic [4:0]    wb_waddr_o;
    logic [DW-1:0] wb_data_o;

    always #5 clk = ~clk;

    ppu_issue_unit #(.PPU_NUM(N), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_waddr_i(req_waddr_i),
        .lane_valid_o(lane_valid_o), .lane_ready_i(lane_ready_i), .lane_op_o(lane_op_o),
        .lane_a_o(lane_a_o), .lane_b_o(lane_b_o),
        .lane_res_valid_i(lane_res_valid_i), .lane_res_i(lane_res_i),
        .lane_res_ready_o(lane_res_ready_o),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_waddr_o(wb_waddr_o),
        .wb_data_o(wb_data_o), .wb_err_o(wb_err_o), .busy_o(busy_o)
    );

    // Reference model: program-ordered list of outstanding instructions.
    typedef struct {
        logic [4:0]    waddr;
        logic [DW-1:0] data;
        bit            err;
        int            lane;
        bit            avail;
    } exp_t;
    // Lane environment: in-order ops per lane with the cycle their result appears.
    typedef struct {
        int            lane;
        logic [DW-1:0] data;
        int            rdy;
    } lop_t;

    exp_t         mq[$];
    lop_t         lq[$];
    logic [N-1:0] iss_log[$];
    logic [4:0]   wa_log[$];
    logic [DW-1:0] wd_log[$];
    int rr_m, cyc, n_cmp, n_bad;
    int lat [N];

    function automatic logic [DW-1:0] lane_fn(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        return a ^ b ^ ({29'd0, op} << 12);
    endfunction

    function automatic bit is_illegal(input logic [2:0] op);
`ifdef PPU_OP_CHECK_EN
        return op >= 3'd6;
`else
        return (op >= 3'd6) && 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // One clock: drive lane results, check outputs against the model, advance.
    task automatic cycle();
        bit            illegal, acc, exp_rdy, exp_wbv, pop;
        logic [N-1:0]  exp_lv, exp_lrr, cap, iss_v;
        logic [DW-1:0] iss_d;
        lane_res_valid_i = '0;
        lane_res_i       = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                for (int j = 0; j < lq.size(); j++) begin
                    if (lq[j].lane == k) begin
                        if (lq[j].rdy <= cyc) begin
                            lane_res_valid_i[k] = 1'b1;
                            lane_res_i[k*DW +: DW] = lq[j].data;
                        end
                        break;
                    end
                end
            end
        end
        #1;
        illegal = is_illegal(req_op_i);
        exp_rdy = !rst && (mq.size() < TD) && (illegal || lane_ready_i[rr_m]);
        acc     = req_valid_i && exp_rdy;
        exp_lv  = '0;
        if (acc && !illegal) exp_lv[rr_m] = 1'b1;
        exp_wbv = 1'b0;
        if (mq.size() > 0) exp_wbv = mq[0].avail;
        exp_lrr = '1;
        foreach (mq[i]) if (mq[i].avail && !mq[i].err) exp_lrr[mq[i].lane] = 1'b0;

        chk("req_ready", req_ready_o, exp_rdy);
        chk("lane_valid", lane_valid_o, exp_lv);
        if (!rst) begin
            chk("busy", busy_o, mq.size() > 0);
            chk("lane_res_ready", lane_res_ready_o, exp_lrr);
            chk("wb_valid", wb_valid_o, exp_wbv);
            if (exp_wbv) begin
                chk("wb_waddr", wb_waddr_o, mq[0].waddr);
                chk("wb_data", wb_data_o, mq[0].data);
                chk("wb_err", wb_err_o, mq[0].err);
            end else begin
                chk("wb_err_idle", wb_err_o, 0);
            end
            if (exp_lv != '0) begin
                chk("lane_op", lane_op_o, req_op_i);
                chk("lane_a", lane_a_o, req_a_i);
                chk("lane_b", lane_b_o, req_b_i);
            end
        end
        if (lane_valid_o != '0) iss_log.push_back(lane_valid_o);
        if (wb_valid_o && wb_ready_i) begin
            wa_log.push_back(wb_waddr_o);
            wd_log.push_back(wb_data_o);
        end
        cap   = lane_res_valid_i & lane_res_ready_o;
        iss_v = lane_valid_o & lane_ready_i;
        iss_d = lane_fn(lane_op_o, lane_a_o, lane_b_o);
        pop   = exp_wbv && wb_ready_i;

        @(posedge clk);
        if (rst) begin
            mq.delete();
            lq.delete();
            rr_m = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (cap[k]) begin
                    for (int j = 0; j < lq.size(); j++) begin
                        if (lq[j].lane == k) begin lq.delete(j); break; end
                    end
                end
                if (iss_v[k]) lq.push_back('{lane: k, data: iss_d, rdy: cyc + lat[k]});
                if (lane_res_valid_i[k] && exp_lrr[k]) begin
                    for (int j = 0; j < mq.size(); j++) begin
                        if (mq[j].lane == k && !mq[j].avail && !mq[j].err) begin
                            mq[j].avail = 1'b1;
                            break;
                        end
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back('{waddr: req_waddr_i,
                               data: illegal ? '0 : lane_fn(req_op_i, req_a_i, req_b_i),
                               err: illegal, lane: illegal ? -1 : rr_m, avail: illegal});
                if (!illegal) rr_m = (rr_m + 1) % N;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] wa, input logic [DW-1:0] a, input logic [DW-1:0] b);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_waddr_i = wa;
        req_a_i     = a;
        req_b_i     = b;
        cycle();
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        req_valid_i  = 1'b0;
        wb_ready_i   = 1'b1;
        lane_ready_i = '1;
        while (mq.size() > 0 && t < 60) begin
            cycle();
            t++;
        end
        chk("drain_done", mq.size(), 0);
    endtask

    task automatic clear_logs();
        iss_log.delete();
        wa_log.delete();
        wd_log.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] oh;
        n_cmp = 0; n_bad = 0; cyc = 0; rr_m = 0;
        rst = 1'b1; req_valid_i = 1'b0; req_op_i = '0; req_a_i = '0; req_b_i = '0;
        req_waddr_i = '0; lane_ready_i = '1; wb_ready_i = 1'b0;
        lane_res_valid_i = '0; lane_res_i = '0;
        lat[0] = 1; lat[1] = 1;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_err", wb_err_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_lane_valid", lane_valid_o, 0);
        chk("rst_lane_res_ready", lane_res_ready_o, 2'b11);
        chk("rst_req_ready", req_ready_o, 1);

        // ADD/SUB/MUL round-robin, in-order writeback
        wb_ready_i = 1'b1;
        clear_logs();
        issue(PPU_ADD, 5'd5, 32'h1111_0000, 32'h0000_2222);
        issue(PPU_SUB, 5'd6, 32'h3333_0000, 32'h0000_4444);
        issue(PPU_MUL, 5'd7, 32'h5555_0000, 32'h0000_6666);
        drain();
        chk("t1_iss_n", iss_log.size(), 3);
        chk("t1_wb_n", wa_log.size(), 3);
        if (iss_log.size() == 3) begin
            chk("t1_iss0", iss_log[0], 2'b01);
            chk("t1_iss1", iss_log[1], 2'b10);
            chk("t1_iss2", iss_log[2], 2'b01);
        end
        if (wa_log.size() == 3) begin
            chk("t1_wa0", wa_log[0], 5);
            chk("t1_wa1", wa_log[1], 6);
            chk("t1_wa2", wa_log[2], 7);
        end

        // Lane 1 finishes two cycles before lane 0; writeback stays in order
        if (rr_m != 0) begin
            issue(PPU_ADD, 5'd1, 32'd1, 32'd2);
            drain();
        end
        clear_logs();
        lat[0] = 4; lat[1] = 1;
        issue(PPU_ADD, 5'd8, 32'h3C00_0000, 32'h0);
        issue(PPU_ADD, 5'd9, 32'h4000_0000, 32'h0);
        drain();
        chk("t2_wb_n", wd_log.size(), 2);
        if (wd_log.size() == 2) begin
            chk("t2_wd0", wd_log[0], 32'h3C00_0000);
            chk("t2_wd1", wd_log[1], 32'h4000_0000);
            chk("t2_wa0", wa_log[0], 8);
            chk("t2_wa1", wa_log[1], 9);
        end

        // Full queue: no bypass on the pop cycle
        lat[0] = 1; lat[1] = 1;
        wb_ready_i = 1'b0;
        clear_logs();
        for (int i = 0; i < 4; i++) issue(PPU_MUL, 5'(10 + i), $urandom, $urandom);
        req_valid_i = 1'b1; req_op_i = PPU_DIV; req_waddr_i = 5'd20;
        req_a_i = 32'h0000_0100; req_b_i = 32'h0000_0003;
        #1;
        chk("full_req_ready", req_ready_o, 0);
        chk("full_busy", busy_o, 1);
        cycle();
        cycle();
        wb_ready_i = 1'b1;
        #1;
        chk("pop_cycle_req_ready", req_ready_o, 0);
        chk("pop_cycle_wb_valid", wb_valid_o, 1);
        cycle();
        #1;
        chk("after_pop_req_ready", req_ready_o, 1);
        cycle();
        req_valid_i = 1'b0;
        drain();
        chk("t3_wb_n", wa_log.size(), 5);
        if (wa_log.size() == 5) begin
            chk("t3_wa0", wa_log[0], 10);
            chk("t3_wa3", wa_log[3], 13);
            chk("t3_wa4", wa_log[4], 20);
        end

        // rr=1 with only lane 0 ready: stall, no skip-ahead
        if (rr_m == 0) begin
            issue(PPU_ADD, 5'd2, 32'd7, 32'd9);
            drain();
        end
        lane_ready_i = 2'b01;
        req_valid_i = 1'b1; req_op_i = PPU_SUB; req_waddr_i = 5'd21;
        req_a_i = 32'hABCD_0000; req_b_i = 32'h0000_1234;
        #1;
        chk("rr1_stall_ready", req_ready_o, 0);
        chk("rr1_stall_lane", lane_valid_o, 0);
        cycle(); cycle(); cycle();
        lane_ready_i = 2'b11;
        #1;
        chk("rr1_go_ready", req_ready_o, 1);
        chk("rr1_go_lane", lane_valid_o, 2'b10);
        cycle();
        req_valid_i = 1'b0;
        drain();

        // Op 7 handling
        oh = '0;
        oh[rr_m] = 1'b1;
`ifdef PPU_OP_CHECK_EN
        lane_ready_i = '0;
        req_valid_i = 1'b1; req_op_i = 3'd7; req_waddr_i = 5'd22;
        req_a_i = 32'h1; req_b_i = 32'h2;
        #1;
        chk("ill_req_ready", req_ready_o, 1);
        chk("ill_lane_valid", lane_valid_o, 0);
        cycle();
        req_valid_i = 1'b0;
        lane_ready_i = '1;
        wb_ready_i = 1'b1;
        #1;
        chk("ill_wb_valid", wb_valid_o, 1);
        chk("ill_wb_err", wb_err_o, 1);
        chk("ill_wb_data", wb_data_o, 0);
        chk("ill_wb_waddr", wb_waddr_o, 22);
        cycle();
        req_valid_i = 1'b1; req_op_i = PPU_ADD; req_waddr_i = 5'd23;
        #1;
        chk("ill_rr_kept", lane_valid_o, oh);
        cycle();
        req_valid_i = 1'b0;
        drain();
`else
        req_valid_i = 1'b1; req_op_i = 3'd7; req_waddr_i = 5'd22;
        req_a_i = 32'h1; req_b_i = 32'h2;
        #1;
        chk("op7_issued", lane_valid_o, oh);
        cycle();
        req_valid_i = 1'b0;
        drain();
`endif

        // Reset with three ops outstanding
        wb_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) issue(PPU_ADD, 5'(24 + i), $urandom, $urandom);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        chk("rst3_busy", busy_o, 0);
        chk("rst3_wb_valid", wb_valid_o, 0);
        chk("rst3_lane_res_ready", lane_res_ready_o, 2'b11);
        req_valid_i = 1'b1; req_op_i = PPU_ADD; req_waddr_i = 5'd27;
        #1;
        chk("rst3_first_lane", lane_valid_o, 2'b01);
        cycle();
        req_valid_i = 1'b0;
        drain();

        // Randomized traffic against the model
        lat[0] = $urandom_range(1, 3);
        lat[1] = $urandom_range(1, 3);
        for (int i = 0; i < 400; i++) begin
            req_valid_i     = ($urandom_range(0, 3) != 0);
            req_op_i        = 3'($urandom_range(0, 7));
            req_a_i         = $urandom;
            req_b_i         = $urandom;
            req_waddr_i     = 5'($urandom);
            lane_ready_i[0] = ($urandom_range(0, 3) != 0);
            lane_ready_i[1] = ($urandom_range(0, 3) != 0);
            wb_ready_i      = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
